irq_pending_latch: RTL and testbench

Request-capture stage feeding the 8-to-3 priority encoder. Detects rising edges on eight request lines and latches each one as a pending bit until the consumer acknowledges it. Presents the masked pending vector and a valid flag to the encoder. The encoder's 3-bit winner index returns as the acknowledge index, so the handled bit clears and the next-highest request surfaces.

---
 rtl/irq_pending_latch_pkg.sv | 9 +
 rtl/irq_pending_latch_sync_2ff.sv | 27 ++
 rtl/irq_pending_latch.sv | 84 ++++++++
 tb/tb_irq_pending_latch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_pending_latch_pkg.sv
// Shared sizing for the request-capture stage in front of the 8-to-3 priority encoder.
package irq_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = $clog2(N_REQ);

    typedef logic [N_REQ-1:0] req_vec_t;

endpackage : irq_pkg

// File: rtl/irq_pending_latch_sync_2ff.sv
// Two-flop synchroniser, one independent chain per bit, async active-low reset to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture so the second stage sees a settled value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/irq_pending_latch.sv
// Request-capture stage: rising edges on req become pending bits that hold until
// acknowledged by the encoder's winner index. pend/valid/ovf come straight from flops.
// Build option: define IRQ_SYNC_EN to insert a 2-flop synchroniser on req (two extra
// cycles of capture latency); otherwise req must already be synchronous to clk.
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int N_REQ = irq_pkg::N_REQ,
    parameter int IDX_W = irq_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    input  logic             ovf_clr,
    output logic [N_REQ-1:0] pend,
    output logic             valid,
    output logic [N_REQ-1:0] ovf
);

    logic [N_REQ-1:0] req_s;
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] raw_q, raw_d;
    logic [N_REQ-1:0] ovf_q, ovf_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic             valid_q, valid_d;
    logic [N_REQ-1:0] req_rise;
    logic [N_REQ-1:0] ack_hit;
    logic [N_REQ-1:0] ack_clr;

`ifdef IRQ_SYNC_EN
    sync_2ff #(
        .WIDTH (N_REQ)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (req),
        .q_o   (req_s)
    );
`else
    assign req_s = req;
`endif

    // Edge detect, ack decode and next-state for pending/overflow.
    // An ack only counts when the bit is actually pending and unmasked; a fresh
    // edge on the bit being cleared re-arms it, so no event is lost and no
    // overflow is flagged for it.
    always_comb begin
        req_rise = req_s & ~req_q;
        ack_hit  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ack_hit[i] = ack && (ack_idx == IDX_W'(i));
        end
        ack_clr = ack_hit & raw_q & mask;
        raw_d   = (raw_q & ~ack_clr) | req_rise;
        ovf_d   = (req_rise & raw_q & ~ack_clr) | (ovf_q & ~{N_REQ{ovf_clr}});
        pend_d  = raw_d & mask;
        valid_d = |pend_d;
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            raw_q   <= '0;
            ovf_q   <= '0;
            pend_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            req_q   <= req_s;
            raw_q   <= raw_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
        end
    end

    assign pend  = pend_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;

endmodule : irq_pending_latch

// File: tb/tb_irq_pending_latch.sv
// Directed scoreboard bench for irq_pending_latch.
module tb_irq_pending_latch;

`ifdef IRQ_SYNC_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] ack_idx;
    logic       ovf_clr;
    logic [7:0] pend;
    logic       valid;
    logic [7:0] ovf;

    irq_pending_latch dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .mask    (mask),
        .ack     (ack),
        .ack_idx (ack_idx),
        .ovf_clr (ovf_clr),
        .pend    (pend),
        .valid   (valid),
        .ovf     (ovf)
    );

    typedef struct {
        int         tgt;
        logic [7:0] p;
        logic       v;
        logic [7:0] o;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    // Monitor: compare every expectation whose target cycle has been reached.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].tgt <= cyc) begin
            e = sb.pop_front();
            if (e.tgt < cyc) begin
                total++;
                bad++;
                $display("FAIL %s stale got_cycle=%0d want_cycle=%0d", e.nm, cyc, e.tgt);
            end else begin
                chk({e.nm, ".pend"}, pend, e.p);
                chk({e.nm, ".valid"}, {7'd0, valid}, {7'd0, e.v});
                chk({e.nm, ".ovf"}, ovf, e.o);
            end
        end
    end

    task automatic drive(input logic [7:0] r, input logic [7:0] m, input logic a,
                         input logic [2:0] ai, input logic oc);
        @(negedge clk);
        req     = r;
        mask    = m;
        ack     = a;
        ack_idx = ai;
        ovf_clr = oc;
    endtask

    // Drive a new req value and line up ack/ovf_clr with the cycle its edge is seen.
    task automatic edge_step(input logic [7:0] r, input logic [7:0] m, input logic a,
                             input logic [2:0] ai, input logic oc);
        repeat (SX) drive(r, m, 1'b0, 3'd0, 1'b0);
        drive(r, m, a, ai, oc);
    endtask

    task automatic expect1(input logic [7:0] p, input logic v, input logic [7:0] o,
                           input string nm);
        exp_t e;
        e.tgt = cyc + 1;
        e.p   = p;
        e.v   = v;
        e.o   = o;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        req     = 8'h04;
        mask    = 8'hFF;
        ack     = 1'b0;
        ack_idx = 3'd0;
        ovf_clr = 1'b0;
        #12;
        chk("in_reset.pend", pend, 8'h00);
        chk("in_reset.valid", {7'd0, valid}, 8'h00);

        // Line high at reset release counts as one edge.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (SX) drive(8'h04, 8'hFF, 1'b0, 3'd0, 1'b0);
        expect1(8'h04, 1'b1, 8'h00, "rst_edge");
        drive(8'h00, 8'hFF, 1'b0, 3'd0, 1'b0); expect1(8'h04, 1'b1, 8'h00, "hold2");
        drive(8'h00, 8'hFF, 1'b1, 3'd2, 1'b0); expect1(8'h00, 1'b0, 8'h00, "ack2");

        // Two requests, acked back to back, highest first.
        edge_step(8'h82, 8'hFF, 1'b0, 3'd0, 1'b0); expect1(8'h82, 1'b1, 8'h00, "pulse71");
        drive(8'h00, 8'hFF, 1'b1, 3'd7, 1'b0);     expect1(8'h02, 1'b1, 8'h00, "ack7");
        drive(8'h00, 8'hFF, 1'b1, 3'd1, 1'b0);     expect1(8'h00, 1'b0, 8'h00, "ack1");

        // Masked capture, reappears on unmask; ack of a masked bit is ignored.
        edge_step(8'h40, 8'h0F, 1'b0, 3'd0, 1'b0); expect1(8'h00, 1'b0, 8'h00, "masked6");
        drive(8'h00, 8'hFF, 1'b0, 3'd0, 1'b0);     expect1(8'h40, 1'b1, 8'h00, "unmask6");
        drive(8'h00, 8'h0F, 1'b1, 3'd6, 1'b0);     expect1(8'h00, 1'b0, 8'h00, "ackmasked6");
        drive(8'h00, 8'hFF, 1'b0, 3'd0, 1'b0);     expect1(8'h40, 1'b1, 8'h00, "still6");
        drive(8'h00, 8'hFF, 1'b1, 3'd6, 1'b0);     expect1(8'h00, 1'b0, 8'h00, "ack6");

        // Overflow on a second edge while pending, then clear.
        edge_step(8'h08, 8'hFF, 1'b0, 3'd0, 1'b0); expect1(8'h08, 1'b1, 8'h00, "r3");
        edge_step(8'h00, 8'hFF, 1'b0, 3'd0, 1'b0); expect1(8'h08, 1'b1, 8'h00, "r3low");
        edge_step(8'h08, 8'hFF, 1'b0, 3'd0, 1'b0); expect1(8'h08, 1'b1, 8'h08, "ovf3");
        drive(8'h08, 8'hFF, 1'b0, 3'd0, 1'b1);     expect1(8'h08, 1'b1, 8'h00, "ovfclr3");
        drive(8'h08, 8'hFF, 1'b1, 3'd3, 1'b0);     expect1(8'h00, 1'b0, 8'h00, "ack3held");
        drive(8'h08, 8'hFF, 1'b0, 3'd0, 1'b0);     expect1(8'h00, 1'b0, 8'h00, "held_no_event");

        // Overflow set and clear together: set wins.
        edge_step(8'h04, 8'hFF, 1'b0, 3'd0, 1'b0); expect1(8'h04, 1'b1, 8'h00, "r2");
        edge_step(8'h00, 8'hFF, 1'b0, 3'd0, 1'b0); expect1(8'h04, 1'b1, 8'h00, "r2low");
        edge_step(8'h04, 8'hFF, 1'b0, 3'd0, 1'b1); expect1(8'h04, 1'b1, 8'h04, "ovf_setclr");
        edge_step(8'h00, 8'hFF, 1'b0, 3'd0, 1'b1); expect1(8'h04, 1'b1, 8'h00, "ovfclr2");

        // Edge on bit 2 together with its ack: stays pending, no overflow.
        edge_step(8'h04, 8'hFF, 1'b1, 3'd2, 1'b0); expect1(8'h04, 1'b1, 8'h00, "edge_ack2");
        drive(8'h00, 8'hFF, 1'b1, 3'd5, 1'b0);     expect1(8'h04, 1'b1, 8'h00, "ack5_nop");
        drive(8'h00, 8'hFF, 1'b1, 3'd2, 1'b0);     expect1(8'h00, 1'b0, 8'h00, "ack2b");

        // All bits pending, further edges only set ovf.
        edge_step(8'hFF, 8'hFF, 1'b0, 3'd0, 1'b0); expect1(8'hFF, 1'b1, 8'h00, "full");
        edge_step(8'h00, 8'hFF, 1'b0, 3'd0, 1'b0); expect1(8'hFF, 1'b1, 8'h00, "full_low");
        edge_step(8'h11, 8'hFF, 1'b0, 3'd0, 1'b0); expect1(8'hFF, 1'b1, 8'h11, "full_ovf11");
        drain();

        // Asynchronous reset mid-stream, away from any clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.pend", pend, 8'h00);
        chk("async_rst.valid", {7'd0, valid}, 8'h00);
        chk("async_rst.ovf", ovf, 8'h00);
        repeat (2) @(negedge clk);
        chk("rst_hold.pend", pend, 8'h00);

        // req still 11 at release: one fresh edge, old state gone.
        rst_n = 1'b1;
        repeat (SX) drive(8'h11, 8'hFF, 1'b0, 3'd0, 1'b0);
        expect1(8'h11, 1'b1, 8'h00, "post_rst");
        drive(8'h11, 8'hFF, 1'b1, 3'd4, 1'b0); expect1(8'h01, 1'b1, 8'h00, "post_ack4");
        drive(8'h11, 8'hFF, 1'b1, 3'd0, 1'b0); expect1(8'h00, 1'b0, 8'h00, "post_ack0");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_irq_pending_latch
